// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory and write-back stages: datapath
// defaults and the load-size encoding carried down the pipeline.
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  // Load size as presented by the memory stage. The reserved code is
  // treated as a full word by the extender.
  typedef enum logic [1:0] {
    LEN_WORD = 2'b00,
    LEN_BYTE = 2'b01,
    LEN_HALF = 2'b10,
    LEN_RSVD = 2'b11
  } load_len_e;

  // Control bits of the write-back slot.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic halted;
  } wb_ctrl_t;

  // Register-file write enable: only real instructions that target a
  // register other than x0 may write.
  function automatic logic rf_write_en(input logic valid,
                                       input logic reg_write,
                                       input logic dest_nonzero);
    return valid & reg_write & dest_nonzero;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_extender.sv
// Load extender: aligns the memory read word down to the loaded size and
// sign- or zero-extends it. Byte and half data arrive in the top bits of
// the read word; the low bits are undefined and are never looked at.
module load_extender
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] inMemData,
  input  logic [1:0]        inLength,
  input  logic              inUnsigned,
  output logic [DATA_W-1:0] outExtended
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;
  logic        byte_fill;
  logic        half_fill;

  assign byte_w    = inMemData[DATA_W-1 -: 8];
  assign half_w    = inMemData[DATA_W-1 -: 16];
  // Fill bit is the loaded value's own MSB for signed loads, 0 otherwise.
  assign byte_fill = byte_w[7]  & ~inUnsigned;
  assign half_fill = half_w[15] & ~inUnsigned;

  // Select and extend by load size; word and reserved pass through.
  always_comb begin
    outExtended = inMemData;
    case (load_len_e'(inLength))
      LEN_BYTE: outExtended = {{(DATA_W-8){byte_fill}}, byte_w};
      LEN_HALF: outExtended = {{(DATA_W-16){half_fill}}, half_w};
      default:  outExtended = inMemData;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register. Captures the EX/MEM slot once per cycle,
// selects ALU or extended load data, and keeps a sticky halt flag plus a
// retired-instruction counter for debug. Every output comes straight
// from a flop.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop_debug,
  input  logic              flush,
  input  logic              inValid,
  input  logic              inRegWrite,
  input  logic              inMemToReg,
  input  logic [1:0]        inLength,
  input  logic              inUnsigned,
  input  logic              inHalt,
  input  logic [REG_W-1:0]  inWriteReg,
  input  logic [DATA_W-1:0] inALUResult,
  input  logic [DATA_W-1:0] inMemData,
  output logic              outValid,
  output logic              outRegWrite,
  output logic [REG_W-1:0]  outWriteReg,
  output logic [DATA_W-1:0] outWriteData,
  output logic              outHalted,
  output logic [31:0]       outRetired
);

  wb_ctrl_t          ctrl_q, ctrl_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [31:0]       retired_q, retired_d;

  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] sel_data;

  load_extender #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .inMemData   (inMemData),
    .inLength    (inLength),
    .inUnsigned  (inUnsigned),
    .outExtended (load_ext)
  );

  assign sel_data = inMemToReg ? load_ext : inALUResult;

  // Next-state selection: debug freeze holds everything; a halted core
  // and a flush both insert a bubble but keep the last write address and
  // data so downstream forwarding sees stable values.
  always_comb begin
    ctrl_d       = ctrl_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    retired_d    = retired_q;
    if (!stop_debug) begin
      if (ctrl_q.halted || flush) begin
        ctrl_d.valid     = 1'b0;
        ctrl_d.reg_write = 1'b0;
      end else begin
        ctrl_d.valid     = inValid;
        ctrl_d.reg_write = rf_write_en(inValid, inRegWrite, inWriteReg != '0);
        ctrl_d.halted    = inValid & inHalt;
        write_reg_d      = inWriteReg;
        write_data_d     = sel_data;
        if (inValid) retired_d = retired_q + 32'd1;
      end
    end
  end

  // Pipeline register with synchronous reset that discards the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      retired_q    <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      retired_q    <= retired_d;
    end
  end

  assign outValid     = ctrl_q.valid;
  assign outRegWrite  = ctrl_q.reg_write;
  assign outHalted    = ctrl_q.halted;
  assign outWriteReg  = write_reg_q;
  assign outWriteData = write_data_q;
  assign outRetired   = retired_q;

endmodule
